// File: rtl/lut_neuron_pkg.sv
// ---------------------------------------------------------------------------
// lut_neuron_pkg
// Shared definitions for the runtime-programmable LUT neuron:
//   - stateT     : controller state (EMPTY, LOAD, RUN)
//   - calcDepth  : number of table entries for a given address width
// ---------------------------------------------------------------------------
package lut_neuron_pkg;

  // EMPTY: no usable table. LOAD: table being written. RUN: serving lookups.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } stateT;

  // One entry per possible address, so the table covers every input pattern.
  function automatic int calcDepth(input int inBits);
    return 1 << inBits;
  endfunction

endpackage

// File: rtl/lut_neuron_stream_ram.sv
// ---------------------------------------------------------------------------
// lut_table_ram
// DEPTH x OUT_BITS table storage with one synchronous write port and one
// asynchronous read port, intended to map onto distributed (LUT) RAM.
// Contents are not reset.
// Ports:
//   clk       : write clock, rising edge
//   i_wrEn    : write enable
//   i_wrAddr  : write address
//   i_wrData  : write data
//   i_rdAddr  : read address
//   o_rdData  : read data (combinational from i_rdAddr)
// ---------------------------------------------------------------------------
module lut_table_ram
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                i_wrEn,
  input  logic [IN_BITS-1:0]  i_wrAddr,
  input  logic [OUT_BITS-1:0] i_wrData,
  input  logic [IN_BITS-1:0]  i_rdAddr,
  output logic [OUT_BITS-1:0] o_rdData
);

  localparam int DEPTH = calcDepth(IN_BITS);

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] r_mem [DEPTH];

  // Write port: no reset so the array stays a plain RAM primitive.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Read port is asynchronous; the caller registers the result.
  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/lut_neuron_stream.sv
// ---------------------------------------------------------------------------
// lut_neuron_stream
// One neuron's truth table held in runtime-loadable RAM, served over a
// valid/ready stream with one cycle of latency and full backpressure.
// Ports:
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   cfg_start  : pulse, begin (or restart) a full table load at address 0
//   cfg_valid  : cfg_data present; consumed only while loading
//   cfg_data   : table entry for the current load address
//   cfg_ready  : high while loading
//   in_valid   : lookup request present
//   in_data    : lookup address (concatenated quantised inputs)
//   in_ready   : lookup accepted when in_valid is also high
//   out_valid  : out_data holds a result
//   out_data   : table entry for the accepted address
//   out_ready  : downstream takes out_data
//   loaded     : table fully written since the last load start
//   cfg_err    : sticky, cfg_valid arrived outside a load
// ---------------------------------------------------------------------------
module lut_neuron_stream
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_ready,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                out_ready,
  output logic                loaded,
  output logic                cfg_err
);

  localparam int DEPTH = calcDepth(IN_BITS);
  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);

  stateT               r_state;
  logic [IN_BITS-1:0]  r_addr;
  logic                r_outValid;
  logic [OUT_BITS-1:0] r_outData;
  logic                r_loaded;
  logic                r_cfgErr;

  logic                w_wrEn;
  logic                w_accept;
  logic [OUT_BITS-1:0] w_rdData;

  // A restart in the same cycle discards any config word.
  assign w_wrEn = (r_state == LOAD) && cfg_valid && !cfg_start;

  // cfg_start has priority over lookups, and a held result blocks new ones.
  assign in_ready = (r_state == RUN) && !cfg_start && (!r_outValid || out_ready);
  assign w_accept = in_valid && in_ready;

  lut_table_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_ram (
    .clk      (clk),
    .i_wrEn   (w_wrEn),
    .i_wrAddr (r_addr),
    .i_wrData (cfg_data),
    .i_rdAddr (in_data),
    .o_rdData (w_rdData)
  );

  // Controller: walks the load address and enters RUN after the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_addr   <= '0;
      r_loaded <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (cfg_start) begin
            r_state <= LOAD;
            r_addr  <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            r_addr <= '0;
          end else if (cfg_valid) begin
            // Address wraps to 0 naturally after the last entry.
            r_addr <= r_addr + 1'b1;
            if (r_addr == LAST_ADDR) begin
              r_state  <= RUN;
              r_loaded <= 1'b1;
            end
          end
        end
        RUN: begin
          if (cfg_start) begin
            r_state  <= LOAD;
            r_addr   <= '0;
            r_loaded <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

  // Output register: loads on accept, clears on a bare handshake, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outData  <= w_rdData;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  // Config words outside a load are dropped and flagged until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfgErr <= 1'b0;
    end else if (cfg_valid && (r_state != LOAD)) begin
      r_cfgErr <= 1'b1;
    end
  end

  assign cfg_ready = (r_state == LOAD);
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign loaded    = r_loaded;
  assign cfg_err   = r_cfgErr;

endmodule

// File: tb/tb_lut_neuron_stream.sv
// ---------------------------------------------------------------------------
// tb_lut_neuron_stream
// Self-checking bench for lut_neuron_stream. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lut_neuron_stream;

  logic       clk;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic [1:0] cfg_data;
  logic       cfg_ready;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_ready;
  logic       loaded;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference: what the table should hold, and the table being loaded next.
  logic [1:0] model [64];
  logic [1:0] newTable [64];

  typedef struct {
    logic [5:0] addr;
    logic [1:0] expData;
  } vecT;

  vecT vecs [8];

  lut_neuron_stream #(
    .IN_BITS  (6),
    .OUT_BITS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .loaded    (loaded),
    .cfg_err   (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Test pattern: upper four address bits select the entry.
  function automatic logic [1:0] patternEntry(input int a);
    int hi;
    hi = a / 4;
    if (hi == 2 || hi == 7) return 2'b01;
    if (hi == 3) return 2'b11;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Full (or aborted) table load with cfg_valid dropped every third cycle.
  task automatic applyStimulus(input int abortAt);
    int idx;
    int k;
    idx = 0;
    k = 0;
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = 6'd0;
    @(negedge clk);
    checkOutput("load_start_in_ready", in_ready, 0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    while (idx < 64 && idx != abortAt) begin
      cfg_valid = ((k % 3) != 2);
      cfg_data  = newTable[idx];
      in_data   = 6'($urandom_range(0, 63));
      @(negedge clk);
      checkOutput("load_cfg_ready", cfg_ready, 1);
      checkOutput("load_loaded_low", loaded, 0);
      checkOutput("load_in_ready", in_ready, 0);
      @(posedge clk);
      if (cfg_valid) idx++;
      #1;
      k++;
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    if (idx == 64) begin
      @(negedge clk);
      checkOutput("load_loaded_high", loaded, 1);
      checkOutput("load_cfg_ready_low", cfg_ready, 0);
      for (int i = 0; i < 64; i++) model[i] = newTable[i];
      @(posedge clk); #1;
    end
  endtask

  // Single lookup with out_ready held high.
  task automatic lookup(input string name, input logic [5:0] addr,
                        input logic [1:0] expData);
    in_valid  = 1'b1;
    in_data   = addr;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput({name, "_valid"}, out_valid, 1);
    checkOutput({name, "_data"}, out_data, expData);
    @(posedge clk); #1;
  endtask

  // Stream every address back to back with random backpressure.
  task automatic sweep(input string name);
    int sent;
    int recv;
    int cycles;
    logic [1:0] q [$];
    logic holdV;
    logic [1:0] holdD;
    sent = 0;
    recv = 0;
    cycles = 0;
    holdV = 1'b0;
    holdD = 2'b00;
    while (recv < 64 && cycles < 2000) begin
      in_valid  = (sent < 64);
      in_data   = 6'(sent);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (holdV) begin
        checkOutput({name, "_hold_valid"}, out_valid, 1);
        checkOutput({name, "_hold_data"}, out_data, holdD);
      end
      checkOutput({name, "_in_ready"}, in_ready, (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput({name, "_extra_result"}, q.size(), 1);
        end else begin
          checkOutput({name, "_data"}, out_data, q.pop_front());
        end
        recv++;
      end
      holdV = out_valid && !out_ready;
      holdD = out_data;
      if (in_valid && in_ready) begin
        q.push_back(model[in_data]);
        sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({name, "_count"}, recv, 64);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "_drained"}, out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 2'b00;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b1;

    vecs[0] = '{6'b001100, 2'b11};
    vecs[1] = '{6'b011101, 2'b01};
    vecs[2] = '{6'b101010, 2'b00};
    vecs[3] = '{6'b001000, 2'b01};
    vecs[4] = '{6'b011111, 2'b01};
    vecs[5] = '{6'b001111, 2'b11};
    vecs[6] = '{6'b000000, 2'b00};
    vecs[7] = '{6'b111111, 2'b00};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_loaded", loaded, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 0);
    @(posedge clk); #1;

    // Lookups are refused while empty.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 6'($urandom_range(0, 63));
      @(negedge clk);
      checkOutput("empty_in_ready", in_ready, 0);
      checkOutput("empty_out_valid", out_valid, 0);
      checkOutput("empty_loaded", loaded, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    // Pattern load and directed lookups.
    for (int i = 0; i < 64; i++) newTable[i] = patternEntry(i);
    applyStimulus(-1);
    checkOutput("load_cfg_err", cfg_err, 0);
    for (int i = 0; i < 8; i++) lookup("vec", vecs[i].addr, vecs[i].expData);

    sweep("sweep1");

    // Reload while a result is pending under backpressure.
    in_valid  = 1'b1;
    in_data   = 6'b001100;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("pend_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cfg_start = 1'b1;
    @(negedge clk);
    checkOutput("pend_start_in_ready", in_ready, 0);
    checkOutput("pend_start_valid", out_valid, 1);
    checkOutput("pend_start_data", out_data, 2'b11);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 6'($urandom_range(0, 63));
      @(negedge clk);
      checkOutput("pend_cfg_ready", cfg_ready, 1);
      checkOutput("pend_in_ready", in_ready, 0);
      checkOutput("pend_hold_valid", out_valid, 1);
      checkOutput("pend_hold_data", out_data, 2'b11);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("pend_deliver_valid", out_valid, 1);
    checkOutput("pend_deliver_data", out_data, 2'b11);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("pend_drop_valid", out_valid, 0);
    @(posedge clk); #1;

    // Restart the load from inside LOAD with an all-2'b10 table.
    for (int i = 0; i < 64; i++) newTable[i] = 2'b10;
    applyStimulus(-1);
    sweep("sweep_10");

    // Reset in the middle of a load.
    for (int i = 0; i < 64; i++) newTable[i] = patternEntry(i);
    applyStimulus(30);
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_loaded", loaded, 0);
    checkOutput("midrst_cfg_ready", cfg_ready, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 6'($urandom_range(0, 63));
      @(negedge clk);
      checkOutput("midrst_empty_in_ready", in_ready, 0);
      checkOutput("midrst_empty_cfg_ready", cfg_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    applyStimulus(-1);
    for (int i = 0; i < 8; i++) lookup("relvec", vecs[i].addr, vecs[i].expData);

    // Config word while running: flagged, table untouched.
    checkOutput("run_cfg_err_before", cfg_err, 0);
    cfg_valid = 1'b1;
    cfg_data  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("run_cfg_err_set", cfg_err, 1);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("run_cfg_err_sticky", cfg_err, 1);
      @(posedge clk); #1;
    end
    lookup("err_tbl_a", 6'b001100, 2'b11);
    lookup("err_tbl_b", 6'b000000, 2'b00);
    lookup("err_tbl_c", 6'b000001, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_neuron_stream.md
Name: lut_neuron_stream

Overview:
- Runtime-programmable, registered successor to the fixed combinational per-neuron truth-table ROMs in the layer netlists.
- Holds one 2^IN_BITS x OUT_BITS truth table in distributed RAM; the table is loaded over a config stream after reset.
- Serves lookups over a valid/ready stream with one-cycle latency and full backpressure.
- Lets one synthesised neuron be retrained or reloaded without re-synthesis; sits between the input quantiser stage and the next layer's concatenation.

Parameters:
- IN_BITS, 6, table address width (fan-in x input bits per feature).
- OUT_BITS, 2, output activation width.
- DEPTH, 2**IN_BITS, table entries (derived; never overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_start  input  1  pulse: begin a full table load at address 0.
- cfg_valid  input  1  cfg_data word present.
- cfg_data  input  OUT_BITS  table entry for the current load address.
- cfg_ready  output  1  high in LOAD state.
- in_valid  input  1  lookup request present.
- in_data  input  IN_BITS  table address (concatenated quantised inputs).
- in_ready  output  1  lookup accepted this cycle when in_valid is also high.
- out_valid  output  1  out_data holds a result.
- out_data  output  OUT_BITS  table entry for the accepted in_data.
- out_ready  input  1  downstream accepts out_data.
- loaded  output  1  table fully written since the last load start.
- cfg_err  output  1  sticky: cfg_valid seen outside LOAD.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values: state=EMPTY, load address=0, out_valid=0, out_data=0, loaded=0, cfg_err=0. Table RAM is not reset; its contents are undefined until loaded.
- FSM states and transitions:
  - EMPTY: cfg_start -> LOAD.
  - LOAD: cfg_valid -> write RAM[addr]=cfg_data, addr++. The write of addr==DEPTH-1 -> RUN, loaded=1, addr wraps to 0.
  - RUN: cfg_start -> LOAD, loaded=0, addr=0.
- cfg_start while in LOAD restarts the load at addr 0; any cfg_valid in that same cycle is discarded.
- cfg_ready is high only in LOAD.
- cfg_valid in EMPTY or RUN: data is discarded and cfg_err is set. cfg_err clears only on rst.
- in_ready = (state==RUN) && !cfg_start && (!out_valid || out_ready). It is combinational; no in_valid -> in_ready dependency.
- Accept (in_valid && in_ready): next cycle out_valid=1 and out_data=RAM[in_data]. Latency 1 cycle; throughput 1 per cycle under continuous out_ready.
- out_valid and out_data hold stable while out_valid && !out_ready.
- Output handshake (out_valid && out_ready) without a new accept: out_valid drops next cycle.
- Handshake and accept in the same cycle: out_valid stays 1 with the new data.
- Reload from RUN: in-flight out_data still drains normally (it was read before any rewrite). No new accepts until RUN is re-entered.
- Reset mid-load: returns to EMPTY with loaded=0. A partial table is never usable.
- Lookup of any address is legal. Width rules: in_data is used unmodified as the RAM address; there is no arithmetic.
- Simultaneous cfg_start and in_valid in RUN: cfg_start wins and the lookup is not accepted.
- Read is asynchronous from distributed RAM into the out_data register.

Decomposition:
- Shared package (lut_neuron_pkg): the FSM state enum (EMPTY, LOAD, RUN) and a helper function for the DEPTH calculation.
- Sub-module lut_table_ram: DEPTH x OUT_BITS RAM with one synchronous write port and one asynchronous read port, with a distributed ROM/RAM style attribute.
- FSM, load counter and output register stay in the top module.

Test Plan:
- Reset then in_valid=1 -> in_ready=0, out_valid=0, loaded=0 for 20 cycles.
- Load pattern: entry=2'b01 where addr[5:2]=4'b0010 or 4'b0111, entry=2'b11 where addr[5:2]=4'b0011, else 2'b00, with cfg_valid gapped every 3rd cycle.
  - loaded rises on the cycle after the 64th write.
  - Lookup 6'b001100 -> out_data 2'b11 next cycle; 6'b011101 -> 2'b01; 6'b101010 -> 2'b00.
- Back-to-back 64-address sweep with random out_ready -> results match the model in order; out_data is stable whenever out_valid && !out_ready; no drops or duplicates.
- cfg_start in RUN with a result pending and out_ready=0 -> pending result is held, then delivered when out_ready=1. in_ready=0 until the reload completes. Reload all-2'b10 -> every lookup returns 2'b10.
- rst asserted after 30 load writes -> state EMPTY, loaded=0, in_ready=0. A fresh full load is then required before any lookup is accepted.
- cfg_valid=1 in RUN -> cfg_err=1 and stays 1; table is unchanged (lookup 6'b001100 still returns 2'b11).
